// File: rtl/mod_counter.sv
// Modulo up/down counter with wrap, saturate and one-shot modes.
// Terminal count is a registered pulse; an overflow flag holds it until clear or reset.
module mod_counter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  limit,
    input  logic [STEP_W-1:0] step,
    input  logic              up_down,
    input  logic              count_en,
    input  logic [1:0]        mode,
    input  logic              start,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              ovf_sticky,
    output logic              busy
);

    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned EW = WIDTH + 2;

    localparam logic [1:0] MODE_SAT = 2'b01;
    localparam logic [1:0] MODE_ONE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;

    logic [SW-1:0]    lim1_s, step_s, eff_s;
    logic [EW-1:0]    cnt_e, lim_e, s_e, sum_e, diff_e, up_wrap_e, dn_wrap_e;
    logic             oneshot, step_go, out_of_range;
    logic [WIDTH-1:0] step_res;
    logic             step_tc;

    // Wide operands so that count+s and count+limit+1 never truncate
    always_comb begin
        lim1_s       = SW'(limit) + SW'(1);
        step_s       = SW'(step);
        eff_s        = (step_s > lim1_s) ? lim1_s : step_s;
        cnt_e        = EW'(count_q);
        lim_e        = EW'(limit);
        s_e          = EW'(eff_s);
        sum_e        = cnt_e + s_e;
        diff_e       = cnt_e - s_e;
        up_wrap_e    = sum_e - (lim_e + EW'(1));
        dn_wrap_e    = cnt_e + lim_e + EW'(1) - s_e;
        out_of_range = (cnt_e > lim_e);
    end

    // Result of one enabled step for the current mode and direction
    always_comb begin
        step_res = count_q;
        step_tc  = 1'b0;
        if (eff_s == '0) begin
            step_res = count_q;
        end else if (out_of_range) begin
            step_res = up_down ? '0 : limit;
            step_tc  = 1'b1;
        end else if (mode == MODE_ONE) begin
            // one-shot finishes when the rail is reached, not only when passed
            if (up_down) begin
                if (sum_e >= lim_e) begin
                    step_res = limit;
                    step_tc  = 1'b1;
                end else begin
                    step_res = WIDTH'(sum_e);
                end
            end else begin
                if (s_e >= cnt_e) begin
                    step_res = '0;
                    step_tc  = 1'b1;
                end else begin
                    step_res = WIDTH'(diff_e);
                end
            end
        end else if (mode == MODE_SAT) begin
            if (up_down) begin
                if (sum_e > lim_e) begin
                    step_res = limit;
                    step_tc  = 1'b1;
                end else begin
                    step_res = WIDTH'(sum_e);
                end
            end else begin
                if (s_e > cnt_e) begin
                    step_res = '0;
                    step_tc  = 1'b1;
                end else begin
                    step_res = WIDTH'(diff_e);
                end
            end
        end else begin
            if (up_down) begin
                if (sum_e > lim_e) begin
                    step_res = WIDTH'(up_wrap_e);
                    step_tc  = 1'b1;
                end else begin
                    step_res = WIDTH'(sum_e);
                end
            end else begin
                if (cnt_e >= s_e) begin
                    step_res = WIDTH'(diff_e);
                end else begin
                    step_res = WIDTH'(dn_wrap_e);
                    step_tc  = 1'b1;
                end
            end
        end
    end

    // Next state: clear > load > step; load never moves the FSM
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        oneshot = (mode == MODE_ONE);
        step_go = count_en && (!oneshot || (state_q == ST_RUN));

        if (clear) begin
            count_d = '0;
            state_d = ST_IDLE;
            ovf_d   = 1'b0;
        end else begin
            if (load) begin
                count_d = (load_val > limit) ? limit : load_val;
            end else if (step_go) begin
                count_d = step_res;
                tc_d    = step_tc;
            end

            if (!oneshot) begin
                state_d = ST_IDLE;
            end else if (!load) begin
                case (state_q)
                    ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
                    ST_RUN:           if (step_go && step_tc) state_d = ST_DONE;
                    default:          state_d = ST_IDLE;
                endcase
            end

            ovf_d = ovf_q | tc_d;
        end

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    assign count      = count_q;
    assign tc         = tc_q;
    assign ovf_sticky = ovf_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter (WIDTH=8, STEP_W=4).
module tb_mod_counter;

    logic       clk, rst_n, clear, load, up_down, count_en, start;
    logic [7:0] load_val, limit;
    logic [3:0] step;
    logic [1:0] mode;
    logic [7:0] count;
    logic       tc, ovf_sticky, busy;

    int n_cmp = 0;
    int n_err = 0;

    mod_counter #(.WIDTH(8), .STEP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
        .limit(limit), .step(step), .up_down(up_down), .count_en(count_en),
        .mode(mode), .start(start), .count(count), .tc(tc),
        .ovf_sticky(ovf_sticky), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0; limit = '0;
        step = '0; up_down = 1'b1; count_en = 1'b0; mode = 2'b00; start = 1'b0;
        #2;
        n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL reset count got %0d want 0", count); end
        n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL reset tc got %b want 0", tc); end
        n_cmp++; if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL reset ovf got %b want 0", ovf_sticky); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy got %b want 0", busy); end
        #10 rst_n = 1'b1;
    endtask

    task automatic test_wrap_up();
        logic [7:0] exp_c [4];
        logic       exp_t [4];
        exp_c = '{8'd3, 8'd6, 8'd9, 8'd2};
        exp_t = '{1'b0, 1'b0, 1'b0, 1'b1};
        clear = 1'b1; tick(); clear = 1'b0;
        mode = 2'b00; limit = 8'd9; step = 4'd3; up_down = 1'b1; count_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (count !== exp_c[i]) begin n_err++; $display("FAIL wrap_up[%0d] count got %0d want %0d", i, count, exp_c[i]); end
            n_cmp++; if (tc !== exp_t[i]) begin n_err++; $display("FAIL wrap_up[%0d] tc got %b want %b", i, tc, exp_t[i]); end
        end
        n_cmp++; if (ovf_sticky !== 1'b1) begin n_err++; $display("FAIL wrap_up ovf got %b want 1", ovf_sticky); end
        count_en = 1'b0;
        tick();
        n_cmp++; if (count !== 8'd2) begin n_err++; $display("FAIL wrap_up hold count got %0d want 2", count); end
        n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL wrap_up hold tc got %b want 0", tc); end
        n_cmp++; if (ovf_sticky !== 1'b1) begin n_err++; $display("FAIL wrap_up sticky got %b want 1", ovf_sticky); end
    endtask

    task automatic test_wrap_down();
        load = 1'b1; load_val = 8'd2; tick(); load = 1'b0;
        n_cmp++; if (count !== 8'd2) begin n_err++; $display("FAIL wrap_dn load got %0d want 2", count); end
        up_down = 1'b0; step = 4'd4; count_en = 1'b1;
        tick();
        n_cmp++; if (count !== 8'd8) begin n_err++; $display("FAIL wrap_dn count got %0d want 8", count); end
        n_cmp++; if (tc !== 1'b1) begin n_err++; $display("FAIL wrap_dn tc got %b want 1", tc); end
        step = 4'd15;
        tick();
        n_cmp++; if (count !== 8'd8) begin n_err++; $display("FAIL wrap_dn s15 count got %0d want 8", count); end
        n_cmp++; if (tc !== 1'b1) begin n_err++; $display("FAIL wrap_dn s15 tc got %b want 1", tc); end
        up_down = 1'b1;
        tick();
        n_cmp++; if (count !== 8'd8) begin n_err++; $display("FAIL wrap_up s15 count got %0d want 8", count); end
        n_cmp++; if (tc !== 1'b1) begin n_err++; $display("FAIL wrap_up s15 tc got %b want 1", tc); end
        count_en = 1'b0;
    endtask

    task automatic test_saturate();
        mode = 2'b01; limit = 8'd200; step = 4'd15; up_down = 1'b1;
        load = 1'b1; load_val = 8'd190; tick(); load = 1'b0;
        count_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (count !== 8'd200) begin n_err++; $display("FAIL sat_up[%0d] count got %0d want 200", i, count); end
            n_cmp++; if (tc !== 1'b1) begin n_err++; $display("FAIL sat_up[%0d] tc got %b want 1", i, tc); end
        end
        count_en = 1'b0;
        tick();
        n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL sat idle tc got %b want 0", tc); end
        load = 1'b1; load_val = 8'd100; tick(); load = 1'b0;
        count_en = 1'b1;
        tick();
        n_cmp++; if (count !== 8'd115) begin n_err++; $display("FAIL sat mid count got %0d want 115", count); end
        n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL sat mid tc got %b want 0", tc); end
        count_en = 1'b0;
        load = 1'b1; load_val = 8'd5; tick(); load = 1'b0;
        up_down = 1'b0; count_en = 1'b1;
        tick();
        n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL sat_dn count got %0d want 0", count); end
        n_cmp++; if (tc !== 1'b1) begin n_err++; $display("FAIL sat_dn tc got %b want 1", tc); end
        count_en = 1'b0;
    endtask

    task automatic test_oneshot();
        mode = 2'b10; limit = 8'd5; step = 4'd1; up_down = 1'b1;
        clear = 1'b1; tick(); clear = 1'b0;
        load = 1'b1; load_val = 8'd0; tick(); load = 1'b0;
        count_en = 1'b1;
        tick();
        n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL os idle count got %0d want 0", count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL os idle busy got %b want 0", busy); end
        start = 1'b1; count_en = 1'b0; tick(); start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL os start busy got %b want 1", busy); end
        count_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++; if (count !== 8'(i)) begin n_err++; $display("FAIL os run[%0d] count got %0d want %0d", i, count, i); end
            n_cmp++; if (tc !== (i == 5)) begin n_err++; $display("FAIL os run[%0d] tc got %b want %b", i, tc, (i == 5)); end
            n_cmp++; if (busy !== (i != 5)) begin n_err++; $display("FAIL os run[%0d] busy got %b want %b", i, busy, (i != 5)); end
        end
        tick();
        n_cmp++; if (count !== 8'd5) begin n_err++; $display("FAIL os done count got %0d want 5", count); end
        n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL os done tc got %b want 0", tc); end
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL os restart busy got %b want 1", busy); end
        n_cmp++; if (count !== 8'd5) begin n_err++; $display("FAIL os restart count got %0d want 5", count); end
        tick();
        n_cmp++; if (tc !== 1'b1) begin n_err++; $display("FAIL os rail tc got %b want 1", tc); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL os rail busy got %b want 0", busy); end
        count_en = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        load = 1'b1; load_val = 8'd2; tick(); load = 1'b0;
        n_cmp++; if (count !== 8'd2) begin n_err++; $display("FAIL os run_load count got %0d want 2", count); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL os run_load busy got %b want 1", busy); end
        mode = 2'b00; tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL os mode_exit busy got %b want 0", busy); end
    endtask

    task automatic test_priority();
        mode = 2'b00; limit = 8'd100; step = 4'd3; up_down = 1'b1;
        clear = 1'b1; load = 1'b1; load_val = 8'd77; count_en = 1'b1;
        tick();
        clear = 1'b0; count_en = 1'b0;
        n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL prio count got %0d want 0", count); end
        n_cmp++; if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL prio ovf got %b want 0", ovf_sticky); end
        load_val = 8'd250; tick(); load = 1'b0;
        n_cmp++; if (count !== 8'd100) begin n_err++; $display("FAIL load_clamp count got %0d want 100", count); end
        limit = 8'd50; count_en = 1'b1; tick();
        n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL oor_up count got %0d want 0", count); end
        n_cmp++; if (tc !== 1'b1) begin n_err++; $display("FAIL oor_up tc got %b want 1", tc); end
        count_en = 1'b0;
        mode = 2'b01; limit = 8'd100; load = 1'b1; load_val = 8'd100; tick(); load = 1'b0;
        limit = 8'd50; up_down = 1'b0; count_en = 1'b1; tick();
        n_cmp++; if (count !== 8'd50) begin n_err++; $display("FAIL oor_dn count got %0d want 50", count); end
        n_cmp++; if (tc !== 1'b1) begin n_err++; $display("FAIL oor_dn tc got %b want 1", tc); end
        count_en = 1'b0;
    endtask

    task automatic test_async_reset();
        mode = 2'b10; limit = 8'd5; step = 4'd1; up_down = 1'b1;
        load = 1'b1; load_val = 8'd0; tick(); load = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        count_en = 1'b1; tick(); tick();
        n_cmp++; if (count !== 8'd2) begin n_err++; $display("FAIL ar pre count got %0d want 2", count); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ar pre busy got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL ar count got %0d want 0", count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar busy got %b want 0", busy); end
        n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL ar tc got %b want 0", tc); end
        n_cmp++; if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL ar ovf got %b want 0", ovf_sticky); end
        #2 rst_n = 1'b1;
        tick(); tick();
        n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL ar idle count got %0d want 0", count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar idle busy got %b want 0", busy); end
        start = 1'b1; tick(); start = 1'b0;
        tick();
        n_cmp++; if (count !== 8'd1) begin n_err++; $display("FAIL ar rerun count got %0d want 1", count); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ar rerun busy got %b want 1", busy); end
        count_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_oneshot();
        test_priority();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
